register_ram_arbiter: RTL and testbench

//  Shares the single-port 8x32 register RAM (write-enabled, byte-enabled, 1-cycle read) between two requesters, A and B.
//  A is the microcode/datapath side; B is the exception/debug side.

---
 rtl/register_ram_arbiter_pkg.sv | 31 +++
 rtl/register_read_format.sv | 21 ++
 rtl/register_ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_register_ram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_ram_arbiter_pkg.sv
// Shared definitions for the register RAM arbiter: operand size codes, FSM states,
// grant identity and the size-to-byte-enable decode.
package register_ram_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_LONG = 2'b10;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StAck
    } state_e;

    typedef enum logic {
        GrantA,
        GrantB
    } grant_e;

    // Size code 11 is treated as a long access.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001;
            SIZE_WORD: be = 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/register_read_format.sv
// Formats raw RAM read data according to operand size, with optional sign extension
// of byte and word reads.
module register_read_format
    import register_ram_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (size)
            SIZE_BYTE: result = {{24{sext & data[7]}}, data[7:0]};
            SIZE_WORD: result = {{16{sext & data[15]}}, data[15:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/register_ram_arbiter.sv
// Round-robin arbiter sharing a single-port byte-enabled register RAM between requesters
// A and B; clears the RAM after reset and formats read data for the acknowledged port.
module register_ram_arbiter
    import register_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [1:0]            a_size,
    input  logic                  a_sext,
    input  logic [31:0]           a_wdata,
    output logic                  a_ack,
    output logic [31:0]           a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [1:0]            b_size,
    input  logic                  b_sext,
    input  logic [31:0]           b_wdata,
    output logic                  b_ack,
    output logic [31:0]           b_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [3:0]            ram_byte_enable,
    output logic                  ram_write_enable,
    output logic [31:0]           ram_data_input,
    input  logic [31:0]           ram_data_output
);

    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    grant_e                grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  op_we_q, op_we_d;
    logic [1:0]            op_size_q, op_size_d;
    logic                  op_sext_q, op_sext_d;
    logic                  write_enable;
    logic                  grant_b;
    logic [31:0]           read_formatted;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ResetState;
            last_grant_q <= GrantB;
            grant_q      <= GrantA;
            clear_cnt_q  <= '0;
            init_done_q  <= !CLEAR_ON_RESET;
            op_we_q      <= 1'b0;
            op_size_q    <= SIZE_LONG;
            op_sext_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            clear_cnt_q  <= clear_cnt_d;
            init_done_q  <= init_done_d;
            op_we_q      <= op_we_d;
            op_size_q    <= op_size_d;
            op_sext_q    <= op_sext_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        clear_cnt_d     = clear_cnt_q;
        init_done_d     = init_done_q;
        op_we_d         = op_we_q;
        op_size_d       = op_size_q;
        op_sext_d       = op_sext_q;
        ram_address     = '0;
        ram_byte_enable = '0;
        ram_data_input  = '0;
        write_enable    = 1'b0;
        grant_b         = 1'b0;

        unique case (state_q)
            StClear: begin
                ram_address     = clear_cnt_q;
                ram_byte_enable = 4'b1111;
                write_enable    = 1'b1;
                clear_cnt_d     = clear_cnt_q + 1'b1;
                if (clear_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (a_req || b_req) begin
                    // On a tie the requester not granted last time wins.
                    grant_b = b_req && (!a_req || last_grant_q == GrantA);
                    if (grant_b) begin
                        ram_address     = b_addr;
                        ram_byte_enable = size_to_be(b_size);
                        ram_data_input  = b_wdata;
                        write_enable    = b_we;
                        op_we_d         = b_we;
                        op_size_d       = b_size;
                        op_sext_d       = b_sext;
                        grant_d         = GrantB;
                    end else begin
                        ram_address     = a_addr;
                        ram_byte_enable = size_to_be(a_size);
                        ram_data_input  = a_wdata;
                        write_enable    = a_we;
                        op_we_d         = a_we;
                        op_size_d       = a_size;
                        op_sext_d       = a_sext;
                        grant_d         = GrantA;
                    end
                    last_grant_d = grant_b ? GrantB : GrantA;
                    state_d      = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    // Reset drops the state into CLEAR immediately; keep the RAM from being written
    // until reset is actually released.
    assign ram_write_enable = write_enable & reset_n;
    assign init_done        = init_done_q;

    register_read_format u_read_format (
        .size   (op_size_q),
        .sext   (op_sext_q),
        .data   (ram_data_output),
        .result (read_formatted)
    );

    assign a_ack   = (state_q == StAck) && (grant_q == GrantA);
    assign b_ack   = (state_q == StAck) && (grant_q == GrantB);
    assign a_rdata = (a_ack && !op_we_q) ? read_formatted : 32'h0;
    assign b_rdata = (b_ack && !op_we_q) ? read_formatted : 32'h0;

endmodule

// File: tb/tb_register_ram_arbiter.sv
// Directed bench for register_ram_arbiter with a behavioural 8x32 byte-enabled RAM.
module tb_register_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, a_sext, b_req, b_we, b_sext;
    logic [2:0]  a_addr, b_addr;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_ack, b_ack, init_done;
    logic [2:0]  ram_address;
    logic [3:0]  ram_byte_enable;
    logic        ram_write_enable;
    logic [31:0] ram_data_input;
    logic [31:0] ram_data_output;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    register_ram_arbiter #(
        .ADDR_WIDTH     (3),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_size           (a_size),
        .a_sext           (a_sext),
        .a_wdata          (a_wdata),
        .a_ack            (a_ack),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_size           (b_size),
        .b_sext           (b_sext),
        .b_wdata          (b_wdata),
        .b_ack            (b_ack),
        .b_rdata          (b_rdata),
        .init_done        (init_done),
        .ram_address      (ram_address),
        .ram_byte_enable  (ram_byte_enable),
        .ram_write_enable (ram_write_enable),
        .ram_data_input   (ram_data_input),
        .ram_data_output  (ram_data_output)
    );

    // RAM model: read-before-write, junk contents until the DUT clears it.
    logic [31:0] mem [8];
    bit          seeded = 1'b0;
    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hDEAD_0000 | i;
            seeded <= 1'b1;
        end
        ram_data_output <= mem[ram_address];
        if (ram_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byte_enable[b]) mem[ram_address][8*b +: 8] <= ram_data_input[8*b +: 8];
            end
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [2:0]  addr;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit port, bit we, logic [2:0] addr, logic [1:0] size, bit sext,
                                logic [31:0] wdata, logic [3:0] be, logic [31:0] rdata);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.size = size; v.sext = sext;
        v.wdata = wdata; v.be = be; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input bit port, input vec_t v, input bit req);
        if (port) begin
            b_req = req; b_we = v.we; b_addr = v.addr; b_size = v.size;
            b_sext = v.sext; b_wdata = v.wdata;
        end else begin
            a_req = req; a_we = v.we; a_addr = v.addr; a_size = v.size;
            a_sext = v.sext; a_wdata = v.wdata;
        end
    endtask

    // Caller is #1 after a rising edge with the arbiter in IDLE.
    task automatic txn(input vec_t v, input string name);
        int lat;
        logic own_ack, oth_ack;
        logic [31:0] own_rd, oth_rd;
        drive_port(v.port, v, 1'b1);
        #1;
        chk({name, " addr"}, 32'(ram_address), 32'(v.addr));
        chk({name, " we"}, 32'(ram_write_enable), 32'(v.we));
        chk({name, " be"}, 32'(ram_byte_enable), 32'(v.be));
        if (v.we) chk({name, " wdata"}, ram_data_input, v.wdata);
        lat = 0;
        own_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            lat++;
            own_ack = v.port ? b_ack : a_ack;
            if (own_ack) break;
        end
        oth_ack = v.port ? a_ack : b_ack;
        own_rd  = v.port ? b_rdata : a_rdata;
        oth_rd  = v.port ? a_rdata : b_rdata;
        chk({name, " latency"}, 32'(lat), 32'd1);
        chk({name, " other ack"}, 32'(oth_ack), 32'd0);
        chk({name, " other rdata"}, oth_rd, 32'h0);
        if (!v.we) chk({name, " rdata"}, own_rd, v.rdata);
        drive_port(v.port, v, 1'b0);
        @(posedge clock); #1;
        chk({name, " ack pulse"}, 32'(v.port ? b_ack : a_ack), 32'd0);
    endtask

    task automatic wait_init(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc < exp_cycles) begin
                chk({name, " no ack in clear"}, 32'({a_ack, b_ack}), 32'd0);
                chk({name, " init_done low"}, 32'(init_done), 32'd0);
            end
            if (init_done) break;
        end
        chk({name, " clear cycles"}, 32'(cyc), 32'(exp_cycles));
    endtask

    // Both requesters held: expects A ack, gap, B ack, gap, ...
    task automatic both_held(input string name, input logic [31:0] a_exp, input logic [31:0] b_exp);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            chk($sformatf("%s a_ack c%0d", name, k), 32'(a_ack), 32'(k % 4 == 1));
            chk($sformatf("%s b_ack c%0d", name, k), 32'(b_ack), 32'(k % 4 == 3));
            if (a_ack) chk($sformatf("%s a_rdata c%0d", name, k), a_rdata, a_exp);
            if (b_ack) chk($sformatf("%s b_rdata c%0d", name, k), b_rdata, b_exp);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_size = 0; a_sext = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_size = 0; b_sext = 0; b_wdata = 0;

        for (int i = 0; i < 8; i++) tbl.push_back(mk(i[0], 0, 3'(i), 2'b10, 0, 0, 4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3, 2'b10, 0, 32'h1234_5678, 4'hF, 32'h0));
        tbl.push_back(mk(1, 0, 3, 2'b10, 0, 32'h0,         4'hF, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 3, 2'b00, 0, 32'hCCCC_CCAB, 4'h1, 32'h0));
        tbl.push_back(mk(0, 0, 3, 2'b10, 0, 32'h0,         4'hF, 32'h1234_56AB));
        tbl.push_back(mk(1, 0, 3, 2'b00, 1, 32'h0,         4'h1, 32'hFFFF_FFAB));
        tbl.push_back(mk(0, 0, 3, 2'b00, 0, 32'h0,         4'h1, 32'h0000_00AB));
        tbl.push_back(mk(1, 0, 3, 2'b01, 1, 32'h0,         4'h3, 32'h0000_56AB));
        tbl.push_back(mk(0, 1, 5, 2'b01, 0, 32'h9999_8001, 4'h3, 32'h0));
        tbl.push_back(mk(1, 0, 5, 2'b01, 1, 32'h0,         4'h3, 32'hFFFF_8001));
        tbl.push_back(mk(0, 0, 5, 2'b01, 0, 32'h0,         4'h3, 32'h0000_8001));
        tbl.push_back(mk(1, 1, 7, 2'b11, 0, 32'hCAFE_F00D, 4'hF, 32'h0));
        tbl.push_back(mk(0, 0, 7, 2'b11, 1, 32'h0,         4'hF, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 0, 7, 2'b01, 1, 32'h0,         4'h3, 32'hFFFF_F00D));
        tbl.push_back(mk(1, 0, 7, 2'b00, 1, 32'h0,         4'h1, 32'h0000_000D));

        // Reset and clear
        repeat (3) @(posedge clock);
        #1;
        chk("reset we", 32'(ram_write_enable), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        chk("reset acks", 32'({a_ack, b_ack}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("clear addr0", 32'(ram_address), 32'd0);
        chk("clear we", 32'(ram_write_enable), 32'd1);
        chk("clear be", 32'(ram_byte_enable), 32'hF);
        chk("clear data", ram_data_input, 32'h0);
        wait_init("init", 8);

        foreach (tbl[i]) txn(tbl[i], $sformatf("vec%0d", i));

        // Continuous contention after a B grant: A first, then alternating
        a_req = 1; a_we = 0; a_addr = 3; a_size = 2'b10; a_sext = 0;
        b_req = 1; b_we = 0; b_addr = 3; b_size = 2'b00; b_sext = 1;
        both_held("rr", 32'h1234_56AB, 32'hFFFF_FFAB);

        // Requests held across a fresh clear
        reset_n = 1'b0;
        a_req = 1; a_we = 0; a_addr = 3; a_size = 2'b10; a_sext = 0;
        b_req = 1; b_we = 0; b_addr = 7; b_size = 2'b10; b_sext = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        wait_init("clear req", 8);
        both_held("post clear", 32'h0, 32'h0);

        // Reset in the middle of a B read ack
        txn(mk(0, 1, 3, 2'b10, 0, 32'h55AA_55AA, 4'hF, 32'h0), "pre rst wr");
        v = mk(1, 0, 3, 2'b10, 0, 32'h0, 4'hF, 32'h55AA_55AA);
        drive_port(1, v, 1'b1);
        @(posedge clock); #1;
        chk("mid ack b_ack", 32'(b_ack), 32'd1);
        chk("mid ack b_rdata", b_rdata, 32'h55AA_55AA);
        reset_n = 1'b0;
        #1;
        chk("rst b_ack", 32'(b_ack), 32'd0);
        chk("rst b_rdata", b_rdata, 32'h0);
        chk("rst we", 32'(ram_write_enable), 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        drive_port(1, v, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("restart addr0", 32'(ram_address), 32'd0);
        chk("restart we", 32'(ram_write_enable), 32'd1);
        wait_init("reinit", 8);
        txn(mk(1, 0, 3, 2'b10, 0, 32'h0, 4'hF, 32'h0), "after rst rd3");
        txn(mk(0, 0, 7, 2'b10, 0, 32'h0, 4'hF, 32'h0), "after rst rd7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
